freq_divider: RTL and testbench

Clock-frequency divider producing two independent divided-down square-wave outputs from one system clock. Each channel is a modulo-N counter with a registered output, so each output is glitch-free and usable as a clock-enable or slow strobe. The block sits next to the clock source and feeds slow-rate logic and visual or debug indicators. The two channels use separately parameterised ratios so two divide rates are available at once.

---
 rtl/freq_divider.sv | 76 +++++++
 tb/tb_freq_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_divider.sv
// freq_divider
//   Two independent clock dividers driven from one system clock. Each channel
//   is a modulo-DIV counter feeding a registered output, so the outputs are
//   glitch-free square waves usable as slow strobes or clock enables.
//
//   Ports:
//     clk      - system clock, all registers update on the rising edge
//     rst_n    - synchronous reset, ACTIVE-HIGH (historical name)
//     freq_out - clk / DIV_A, high for ceil(DIV_A/2) cycles per period
//     webTest  - clk / DIV_B, high for ceil(DIV_B/2) cycles per period
//
//   Parameters:
//     DIV_A, DIV_B - divide ratios, 2..65535
//     CNT_W        - counter width, 2**CNT_W >= max(DIV_A, DIV_B)
module freq_divider #(
    parameter int DIV_A = 4,
    parameter int DIV_B = 3,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic freq_out,
    output logic webTest
);

    // Reject illegal configurations at elaboration instead of producing a
    // silently wrong waveform.
    if (DIV_A < 2 || DIV_A > 65535) begin : g_bad_div_a
        $error("freq_divider: DIV_A=%0d outside 2..65535", DIV_A);
    end
    if (DIV_B < 2 || DIV_B > 65535) begin : g_bad_div_b
        $error("freq_divider: DIV_B=%0d outside 2..65535", DIV_B);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("freq_divider: CNT_W=%0d outside 1..32", CNT_W);
    end
    if ((64'd1 << CNT_W) < 64'(DIV_A) || (64'd1 << CNT_W) < 64'(DIV_B)) begin : g_narrow_cnt
        $error("freq_divider: CNT_W=%0d too narrow for DIV_A=%0d / DIV_B=%0d",
               CNT_W, DIV_A, DIV_B);
    end

    // Terminal count and high-phase length (ceiling of half the ratio).
    localparam logic [CNT_W-1:0] LAST_A = CNT_W'(DIV_A - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(DIV_B - 1);
    localparam logic [CNT_W-1:0] HIGH_A = CNT_W'(DIV_A - DIV_A / 2);
    localparam logic [CNT_W-1:0] HIGH_B = CNT_W'(DIV_B - DIV_B / 2);

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] cnt_a_next;
    logic [CNT_W-1:0] cnt_b_next;

    // ">=" rather than "==" so an out-of-range count (upset) wraps to 0 on
    // the very next edge instead of running the whole counter range.
    always_comb begin
        cnt_a_next = (cnt_a >= LAST_A) ? '0 : cnt_a + CNT_W'(1);
        cnt_b_next = (cnt_b >= LAST_B) ? '0 : cnt_b + CNT_W'(1);
    end

    // Reset parks the counters at the terminal count so the first edge after
    // release wraps to 0 and drives the outputs high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_a    <= LAST_A;
            cnt_b    <= LAST_B;
            freq_out <= 1'b0;
            webTest  <= 1'b0;
        end else begin
            cnt_a    <= cnt_a_next;
            cnt_b    <= cnt_b_next;
            freq_out <= (cnt_a_next < HIGH_A);
            webTest  <= (cnt_b_next < HIGH_B);
        end
    end

endmodule

// File: tb/tb_freq_divider.sv
// Testbench for freq_divider. Three instances cover the default ratios (4/3),
// the minimum ratio (2/2) and odd ratios (7/5 on a 3-bit counter). The
// reference model predicts each output from the number of edges since reset
// release: edge k (k >= 1) is high when (k-1) mod DIV < DIV - floor(DIV/2).
module tb_freq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic fo_d, wt_d, fo_m, wt_m, fo_o, wt_o;

    always #5 clk = ~clk;

    freq_divider #(.DIV_A(4), .DIV_B(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .freq_out(fo_d), .webTest(wt_d));

    freq_divider #(.DIV_A(2), .DIV_B(2), .CNT_W(2)) dut_min (
        .clk(clk), .rst_n(rst_n), .freq_out(fo_m), .webTest(wt_m));

    freq_divider #(.DIV_A(7), .DIV_B(5), .CNT_W(3)) dut_odd (
        .clk(clk), .rst_n(rst_n), .freq_out(fo_o), .webTest(wt_o));

    wire [5:0] outs = {fo_d, wt_d, fo_m, wt_m, fo_o, wt_o};

    int pass_cnt = 0;
    int total    = 0;
    int k        = 0;   // rising edges since reset release (0 while in reset)

    function automatic logic model(input int div, input int edges);
        if (edges == 0) return 1'b0;
        return ((edges - 1) % div) < (div - div / 2);
    endfunction

    function automatic logic [5:0] exp_vec(input int edges);
        return {model(4, edges), model(3, edges), model(2, edges),
                model(2, edges), model(7, edges), model(5, edges)};
    endfunction

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) k = 0;
        else k++;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b1;
        repeat (n) tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (outs !== 6'b000000)
                $display("FAIL reset_hold edge %0d: got %b want 000000", i, outs);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (outs !== 6'b111111)
            $display("FAIL reset_first_edge: got %b want 111111", outs);
        else pass_cnt++;
    endtask

    task automatic test_ratio(input bit chan_b);
        int div;
        int chg, exp_chg, falls;
        logic prev, eprev, cur, e;
        div = chan_b ? 3 : 4;
        apply_reset(1);
        prev = 1'b0; eprev = 1'b0;
        chg = 0; exp_chg = 0; falls = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cur = chan_b ? wt_d : fo_d;
            e   = model(div, k);
            total++;
            if (cur !== e)
                $display("FAIL ratio_div%0d edge %0d: got %b want %b", div, k, cur, e);
            else pass_cnt++;
            if (cur !== prev) chg++;
            if (prev === 1'b1 && cur === 1'b0) falls++;
            if (e != eprev) exp_chg++;
            prev = cur; eprev = e;
        end
        total++;
        if (chg != exp_chg)
            $display("FAIL ratio_div%0d_changes: got %0d want %0d", div, chg, exp_chg);
        else pass_cnt++;
        total++;
        if (falls != 100 / div)
            $display("FAIL ratio_div%0d_periods: got %0d want %0d", div, falls, 100 / div);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        apply_reset(1);
        repeat (8) tick();          // next edge would raise freq_out
        rst_n = 1'b1;
        tick();
        total++;
        if (outs !== 6'b000000)
            $display("FAIL mid_reset_edge: got %b want 000000", outs);
        else pass_cnt++;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (outs !== exp_vec(k))
                $display("FAIL mid_reset_resume edge %0d: got %b want %b", k, outs, exp_vec(k));
            else pass_cnt++;
        end
    endtask

    task automatic test_min_ratio();
        int chg_a, chg_b;
        logic pa, pb;
        apply_reset(1);
        pa = 1'b0; pb = 1'b0; chg_a = 0; chg_b = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if (fo_m !== model(2, k) || wt_m !== model(2, k))
                $display("FAIL min_ratio edge %0d: got %b%b want %b%b",
                         k, fo_m, wt_m, model(2, k), model(2, k));
            else pass_cnt++;
            if (fo_m !== pa) chg_a++;
            if (wt_m !== pb) chg_b++;
            pa = fo_m; pb = wt_m;
        end
        total++;
        if (chg_a != 100 || chg_b != 100)
            $display("FAIL min_ratio_changes: got %0d/%0d want 100/100", chg_a, chg_b);
        else pass_cnt++;
    endtask

    task automatic test_odd_ratio();
        int hi_run, lo_run;
        bit seen_high;
        logic prev;
        apply_reset(1);
        hi_run = 0; lo_run = 0; seen_high = 0; prev = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            total++;
            if (fo_o !== model(7, k) || wt_o !== model(5, k))
                $display("FAIL odd_ratio edge %0d: got %b%b want %b%b",
                         k, fo_o, wt_o, model(7, k), model(5, k));
            else pass_cnt++;
            total++;
            if (dut_odd.cnt_a > 3'd6)
                $display("FAIL odd_cnt_bound edge %0d: got %0d want <=6", k, dut_odd.cnt_a);
            else pass_cnt++;
            if (prev === 1'b1 && fo_o === 1'b0) begin
                total++;
                if (hi_run != 4) $display("FAIL odd_high_len: got %0d want 4", hi_run);
                else pass_cnt++;
                hi_run = 0;
            end
            if (prev === 1'b0 && fo_o === 1'b1) begin
                if (seen_high) begin
                    total++;
                    if (lo_run != 3) $display("FAIL odd_low_len: got %0d want 3", lo_run);
                    else pass_cnt++;
                end
                seen_high = 1;
                lo_run = 0;
            end
            if (fo_o === 1'b1) hi_run++;
            else lo_run++;
            prev = fo_o;
        end
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (burst > 0) begin
                rst_n = 1'b1;
                burst--;
            end else if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b1;
                burst = int'($urandom_range(0, 2));
            end else begin
                rst_n = 1'b0;
            end
            tick();
            total++;
            if (outs !== exp_vec(k))
                $display("FAIL random edge %0d (k=%0d): got %b want %b", i, k, outs, exp_vec(k));
            else pass_cnt++;
        end
        rst_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ratio(1'b0);
        test_ratio(1'b1);
        test_mid_reset();
        test_min_ratio();
        test_odd_ratio();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
